// File: rtl/ps2_mouse_rx_if.sv
// PS/2 mouse receiver output bundle.
// Decoded movement, buttons and status pulses.
interface ps2_mouse_rx_if;
    logic [7:0] mouse_x;
    logic       is_mouse_x_neg;
    logic [7:0] mouse_y;
    logic       is_mouse_y_neg;
    logic [2:0] mouse_buttons;
    logic       o_valid;
    logic       o_err;

    modport master (
        output mouse_x, is_mouse_x_neg,
        output mouse_y, is_mouse_y_neg,
        output mouse_buttons, o_valid, o_err
    );

    modport slave (
        input mouse_x, is_mouse_x_neg,
        input mouse_y, is_mouse_y_neg,
        input mouse_buttons, o_valid, o_err
    );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: line filter, byte deframer,
// 3-byte packet assembly and sign-magnitude deltas.
module ps2_mouse_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_mouse_rx_if.master mo
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_MAX = TCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} byte_st_t;
    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_st_t;

    logic [1:0]     clk_s_q, dat_s_q;
    logic [FCW-1:0] fcnt_q;
    logic           filt_q, filt_prev_q;
    logic           fall, bit_in;

    byte_st_t       bst_q, bst_d;
    pkt_st_t        pst_q, pst_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     sh_q, sh_d;
    logic           perr_q, perr_d;
    logic [7:0]     b0_q, b0_d, b1_q, b1_d;
    logic [TCW-1:0] to_q, to_d;
    logic [7:0]     x_q, x_d, y_q, y_d;
    logic           xn_q, xn_d, yn_q, yn_d;
    logic [2:0]     btn_q, btn_d;
    logic           valid_q, valid_d, err_q, err_d;

    // Returns {neg, mag}; -256 and overflow both clamp to 255.
    function automatic logic [8:0] conv(
        input logic s, input logic ovf, input logic [7:0] b
    );
        if (ovf)            conv = {s, 8'hFF};
        else if (!s)        conv = {1'b0, b};
        else if (b == 8'h0) conv = {1'b1, 8'hFF};
        else                conv = {1'b1, ~b + 8'd1};
    endfunction

    // Two-flop synchronisers for both PS/2 lines (idle high).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
        end
    end

    // Glitch filter: level follows only after a run of differing samples.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == F_LAST) begin
                filt_q <= clk_s_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    assign fall   = filt_prev_q & ~filt_q;
    assign bit_in = dat_s_q[1];

    // Next-state for byte/packet FSMs, timeout and decoded outputs.
    always_comb begin
        bst_d   = bst_q;
        pst_d   = pst_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        to_d    = to_q;
        x_d     = x_q;
        xn_d    = xn_q;
        y_d     = y_q;
        yn_d    = yn_q;
        btn_d   = btn_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (fall) begin
            to_d = '0;
        end else if ((bst_q != IDLE || pst_q != BYTE0) && to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
            if (to_d == TO_MAX) begin
                err_d = 1'b1;
                bst_d = IDLE;
                pst_d = BYTE0;
            end
        end

        if (fall) begin
            unique case (bst_q)
                IDLE: begin
                    if (!bit_in) begin
                        bst_d  = DATA;
                        bcnt_d = '0;
                        perr_d = 1'b0;
                    end
                end
                DATA: begin
                    sh_d   = {bit_in, sh_q[7:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) bst_d = PARITY;
                end
                PARITY: begin
                    perr_d = ~(^{sh_q, bit_in});
                    bst_d  = STOP;
                end
                STOP: begin
                    bst_d = IDLE;
                    if (!bit_in || perr_q) begin
                        err_d = 1'b1;
                        pst_d = BYTE0;
                    end else begin
                        unique case (pst_q)
                            BYTE0: begin
                                if (sh_q[3]) begin
                                    b0_d  = sh_q;
                                    pst_d = BYTE1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            BYTE1: begin
                                b1_d  = sh_q;
                                pst_d = BYTE2;
                            end
                            BYTE2: begin
                                {xn_d, x_d} = conv(b0_q[4], b0_q[6], b1_q);
                                {yn_d, y_d} = conv(b0_q[5], b0_q[7], sh_q);
                                btn_d   = b0_q[2:0];
                                valid_d = 1'b1;
                                pst_d   = BYTE0;
                            end
                            default: pst_d = BYTE0;
                        endcase
                    end
                end
                default: bst_d = IDLE;
            endcase
        end

        if (valid_d) err_d = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bst_q   <= IDLE;
            pst_q   <= BYTE0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            b0_q    <= '0;
            b1_q    <= '0;
            to_q    <= '0;
            x_q     <= '0;
            xn_q    <= 1'b0;
            y_q     <= '0;
            yn_q    <= 1'b0;
            btn_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bst_q   <= bst_d;
            pst_q   <= pst_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            to_q    <= to_d;
            x_q     <= x_d;
            xn_q    <= xn_d;
            y_q     <= y_d;
            yn_q    <= yn_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign mo.mouse_x        = x_q;
    assign mo.is_mouse_x_neg = xn_q;
    assign mo.mouse_y        = y_q;
    assign mo.is_mouse_y_neg = yn_q;
    assign mo.mouse_buttons  = btn_q;
    assign mo.o_valid        = valid_q;
    assign mo.o_err          = err_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Testbench for ps2_mouse_rx: serial PS/2 stimulus,
// expected packets queued and matched on o_valid.
module tb_ps2_mouse_rx;
    localparam int FL   = 8;
    localparam int TO   = 3000;
    localparam int HALF = 20;
    localparam int GAP  = 100;

    typedef struct packed {
        logic [2:0] btn;
        logic [7:0] x;
        logic       xn;
        logic [7:0] y;
        logic       yn;
    } exp_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    exp_t q[$];
    exp_t last_exp = '0;

    ps2_mouse_rx_if m();

    ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .arst     (arst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .mo       (m)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop and compare on every o_valid.
    always @(negedge clk) begin
        if (!arst) begin
            if (m.o_err) err_cnt++;
            if (m.o_valid) begin
                exp_t e;
                exp_t a;
                valid_cnt++;
                n_checks++;
                a = '{m.mouse_buttons, m.mouse_x, m.is_mouse_x_neg,
                      m.mouse_y, m.is_mouse_y_neg};
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid got=%h", a);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL packet btn/x/xn/y/yn got=%h/%h/%b/%h/%b want=%h/%h/%b/%h/%b",
                                 a.btn, a.x, a.xn, a.y, a.yn,
                                 e.btn, e.x, e.xn, e.y, e.yn);
                    end
                end
            end
        end
    end

    function automatic void model(
        input logic s, input logic ovf, input logic [7:0] b,
        output logic [7:0] mag, output logic neg
    );
        int v;
        v = s ? int'(b) - 256 : int'(b);
        if (ovf) begin
            mag = 8'd255;
            neg = s;
        end else if (v < 0) begin
            neg = 1'b1;
            mag = (-v > 255) ? 8'd255 : 8'(-v);
        end else begin
            neg = 1'b0;
            mag = 8'(v);
        end
    endfunction

    task automatic push_pkt(input logic [7:0] b0, b1, b2);
        exp_t e;
        e.btn = b0[2:0];
        model(b0[4], b0[6], b1, e.x, e.xn);
        model(b0[5], b0[7], b2, e.y, e.yn);
        q.push_back(e);
        last_exp = e;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(~bad_stop);
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2);
        send_byte(b0, 0, 0);
        send_byte(b1, 0, 0);
        send_byte(b2, 0, 0);
        repeat (GAP) @(posedge clk);
    endtask

    task automatic check_counts(input string name, input int v0, e0, dv, de);
        n_checks++;
        if (valid_cnt - v0 !== dv || err_cnt - e0 !== de || q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s valid=%0d err=%0d pending=%0d want valid=%0d err=%0d pending=0",
                     name, valid_cnt - v0, err_cnt - e0, q.size(), dv, de);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({m.mouse_x, m.is_mouse_x_neg, m.mouse_y, m.is_mouse_y_neg,
             m.mouse_buttons, m.o_valid, m.o_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_active outputs=%h want 0", {m.mouse_x, m.mouse_y});
        end
        arst = 1'b0;
        repeat (10000) @(posedge clk);
        #1;
        n_checks++;
        if ({m.mouse_x, m.is_mouse_x_neg, m.mouse_y, m.is_mouse_y_neg,
             m.mouse_buttons, m.o_valid, m.o_err} !== 23'd0
            || valid_cnt !== 0 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_idle x=%h y=%h valid=%0d err=%0d want 0",
                     m.mouse_x, m.mouse_y, valid_cnt, err_cnt);
        end
    endtask

    task automatic test_basic();
        int v0 = valid_cnt, e0 = err_cnt;
        push_pkt(8'h29, 8'h05, 8'hFB);
        send_pkt(8'h29, 8'h05, 8'hFB);
        check_counts("basic", v0, e0, 1, 0);
        n_checks++;
        if (m.mouse_x !== 8'd5 || m.is_mouse_x_neg !== 1'b0 || m.mouse_y !== 8'd5
            || m.is_mouse_y_neg !== 1'b1 || m.mouse_buttons !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_hold x=%0d xn=%b y=%0d yn=%b btn=%b want 5 0 5 1 001",
                     m.mouse_x, m.is_mouse_x_neg, m.mouse_y, m.is_mouse_y_neg, m.mouse_buttons);
        end
    endtask

    task automatic test_boundaries();
        int v0 = valid_cnt, e0 = err_cnt;
        push_pkt(8'h18, 8'h00, 8'h00);
        send_pkt(8'h18, 8'h00, 8'h00);
        check_counts("neg256", v0, e0, 1, 0);
        v0 = valid_cnt;
        push_pkt(8'h48, 8'h10, 8'h00);
        send_pkt(8'h48, 8'h10, 8'h00);
        check_counts("x_ovf", v0, e0, 1, 0);
        v0 = valid_cnt;
        push_pkt(8'hBE, 8'h80, 8'h01);
        send_pkt(8'hBE, 8'h80, 8'h01);
        check_counts("y_ovf_neg", v0, e0, 1, 0);
    endtask

    task automatic test_parity();
        int v0 = valid_cnt, e0 = err_cnt;
        send_byte(8'h08, 0, 0);
        send_byte(8'h33, 1, 0);
        check_counts("bad_parity", v0, e0, 0, 1);
        v0 = valid_cnt;
        e0 = err_cnt;
        push_pkt(8'h08, 8'h01, 8'h02);
        send_pkt(8'h08, 8'h01, 8'h02);
        check_counts("after_parity", v0, e0, 1, 0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'h0C, 0, 1);
        check_counts("bad_stop", v0, e0, 0, 1);
    endtask

    task automatic test_resync();
        int v0 = valid_cnt, e0 = err_cnt;
        send_byte(8'h00, 0, 0);
        check_counts("resync_err", v0, e0, 0, 1);
        v0 = valid_cnt;
        e0 = err_cnt;
        push_pkt(8'h0E, 8'h03, 8'h04);
        send_pkt(8'h0E, 8'h03, 8'h04);
        check_counts("resync_next", v0, e0, 1, 0);
    endtask

    task automatic test_timeout();
        int v0 = valid_cnt, e0 = err_cnt;
        send_byte(8'h08, 0, 0);
        send_byte(8'h07, 0, 0);
        repeat (TO + 10) @(posedge clk);
        check_counts("timeout", v0, e0, 0, 1);
        n_checks++;
        if ({m.mouse_buttons, m.mouse_x, m.is_mouse_x_neg, m.mouse_y, m.is_mouse_y_neg}
            !== last_exp) begin
            n_fail++;
            $display("FAIL timeout_hold x=%h y=%h want x=%h y=%h",
                     m.mouse_x, m.mouse_y, last_exp.x, last_exp.y);
        end
        v0 = valid_cnt;
        e0 = err_cnt;
        push_pkt(8'h38, 8'h7F, 8'h81);
        send_pkt(8'h38, 8'h7F, 8'h81);
        check_counts("after_timeout", v0, e0, 1, 0);
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (5) @(posedge clk);
        #2 arst = 1'b1;
        #1;
        n_checks++;
        if ({m.mouse_x, m.is_mouse_x_neg, m.mouse_y, m.is_mouse_y_neg,
             m.mouse_buttons, m.o_valid, m.o_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid x=%h y=%h btn=%b want 0",
                     m.mouse_x, m.mouse_y, m.mouse_buttons);
        end
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        repeat (20) @(posedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        push_pkt(8'h0D, 8'hF0, 8'h0F);
        send_pkt(8'h0D, 8'hF0, 8'h0F);
        check_counts("after_reset_mid", v0, e0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_parity();
        test_resync();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
